// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: FSM state encodings and port indices for the RAM arbiter.
package ram_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;
  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one synchronous RAM between the CPU and the program loader.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  arb_state_e state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, wr_q, wr_d, ram_en_q, ram_en_d, ram_we_q, ram_we_d, win;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  // A tie goes to the port that did not win last time.
  assign win = (req0 && req1) ? ~last_q : req1;
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    ram_en_d    = ram_en_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      ARB_IDLE: if (req0 || req1) begin
        state_d     = ARB_ACCESS;
        last_d      = win;
        owner_d     = win;
        wr_d        = win ? we1 : we0;
        ram_en_d    = 1'b1;
        ram_we_d    = win ? we1 : we0;
        ram_addr_d  = win ? addr1 : addr0;
        ram_wdata_d = win ? wdata1 : wdata0;
      end
      ARB_ACCESS: begin
        state_d  = ARB_RESP;
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      last_q      <= PORT_LOADER;
      owner_q     <= PORT_CPU;
      wr_q        <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end
  assign gnt0      = (state_q != ARB_IDLE) && (owner_q == PORT_CPU);
  assign gnt1      = (state_q != ARB_IDLE) && (owner_q == PORT_LOADER);
  assign ack0      = (state_q == ARB_RESP) && (owner_q == PORT_CPU);
  assign ack1      = (state_q == ARB_RESP) && (owner_q == PORT_LOADER);
  assign rdata     = (state_q == ARB_RESP && !wr_q) ? ram_rdata : '0;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a 1-cycle registered-read RAM model.
module tb_ram_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, ack0, ack1, ram_en, ram_we;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;
  logic [7:0] mem [16];
  logic pre_we = 1'b1;
  logic [3:0] pre_addr = 4'h3;
  logic [7:0] pre_data = 8'hA5;
  int total = 0, bad = 0;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_ack", {ack0, ack1}, 0);
    chk("rst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
    chk("rst_rdata", rdata, 0);
    pre_we = 1'b0;
    reset = 1'b0;
    // single CPU read of preloaded address 3
    req0 = 1; we0 = 0; addr0 = 4'h3;
    step();
    chk("rd_gnt0_a", gnt0, 1);
    chk("rd_gnt1_a", gnt1, 0);
    chk("rd_en", {ram_en, ram_we}, 2'b10);
    chk("rd_addr", ram_addr, 4'h3);
    chk("rd_ack_a", {ack0, ack1}, 0);
    step();
    chk("rd_gnt0_r", gnt0, 1);
    chk("rd_ack_r", {ack0, ack1}, 2'b10);
    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_en_r", ram_en, 0);
    req0 = 0;
    step();
    chk("rd_idle", {gnt0, gnt1, ack0, ack1}, 0);
    chk("rd_rdata_idle", rdata, 0);
    // loader write then CPU readback
    req1 = 1; we1 = 1; addr1 = 4'hF; wdata1 = 8'h3C;
    step();
    chk("wr_gnt", {gnt0, gnt1}, 2'b01);
    chk("wr_strobe", {ram_en, ram_we}, 2'b11);
    chk("wr_bus", {ram_addr, ram_wdata}, {4'hF, 8'h3C});
    step();
    chk("wr_ack", {ack0, ack1}, 2'b01);
    chk("wr_rdata0", rdata, 0);
    chk("wr_mem", mem[15], 8'h3C);
    req1 = 0;
    step();
    req0 = 1; we0 = 0; addr0 = 4'hF;
    step();
    chk("rb_gnt", {gnt0, gnt1}, 2'b10);
    step();
    chk("rb_ack", {ack0, ack1}, 2'b10);
    chk("rb_rdata", rdata, 8'h3C);
    req0 = 0;
    step();
    // tie right after reset alternates starting with the CPU
    reset = 1;
    step();
    reset = 0;
    req0 = 1; we0 = 0; addr0 = 4'h1;
    req1 = 1; we1 = 0; addr1 = 4'h2;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("tie_gnt%0d", i), {gnt0, gnt1},
          (i % 3 == 2) ? 2'b00 : (((i / 3) % 2 == 0) ? 2'b10 : 2'b01));
      chk($sformatf("tie_ack%0d", i), ack0 | ack1, (i % 3 == 1) ? 1 : 0);
    end
    req0 = 0; req1 = 0;
    // late loader request waits for the CPU access to finish
    req0 = 1;
    step();
    chk("late_gnt0", {gnt0, gnt1}, 2'b10);
    req1 = 1;
    step();
    chk("late_resp", {gnt1, ack0}, 2'b01);
    req0 = 0;
    step();
    chk("late_idle", {gnt0, gnt1}, 0);
    step();
    chk("late_gnt1", {gnt0, gnt1}, 2'b01);
    step();
    req1 = 0;
    step();
    // CPU drops req during ACCESS; access still completes
    req0 = 1;
    step();
    chk("viol_gnt", gnt0, 1);
    req0 = 0;
    step();
    chk("viol_ack", {ack0, ack1}, 2'b10);
    step();
    chk("viol_idle", {gnt0, ack0, ram_en}, 0);
    step();
    chk("viol_stay", {gnt0, gnt1, ack0, ack1}, 0);
    // reset during ACCESS aborts asynchronously
    req0 = 1;
    step();
    chk("mid_en", {ram_en, gnt0}, 2'b11);
    #2 reset = 1;
    #1;
    chk("mid_async", {ram_en, gnt0, ack0}, 0);
    req1 = 1;
    step();
    reset = 0;
    step();
    chk("post_tie", {gnt0, gnt1}, 2'b10);
    step();
    chk("post_ack", {ack0, ack1}, 2'b10);
    req0 = 0; req1 = 0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
